// File: rtl/alu_pkg.sv
// Shared definitions for the nibble packer: lane/width defaults, the FILL/FULL
// state encoding and the lane-index type.
package alu_pkg;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 4;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } pack_state_e;

  typedef logic [$clog2(LANES_DEF)-1:0] lane_idx_t;

  // Lane-index width for an arbitrary lane count; a single lane still needs one bit.
  function automatic int idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/nibble_pack16_if.sv
// Handshake bundle between upstream lane source, packer and downstream word sink.
// NIBBLE_PACK_PARITY_EN adds the out_parity signal.
interface nibble_pack16_if #(
  parameter int LANES  = alu_pkg::LANES_DEF,
  parameter int LANE_W = alu_pkg::LANE_W_DEF
) ();

  logic [LANE_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [LANES*LANE_W-1:0] out_data;
  logic [LANES-1:0]        out_lanes;
  logic                    out_valid;
  logic                    out_ready;

`ifdef NIBBLE_PACK_PARITY_EN
  logic                    out_parity;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_lanes, out_valid, out_parity
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_lanes, out_valid, out_parity
  );
`else
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_lanes, out_valid
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_lanes, out_valid
  );
`endif

endinterface

// File: rtl/nibble_pack16.sv
// Packs LANES narrow lanes into one word with valid/ready on both sides and flush.
// NIBBLE_PACK_PARITY_EN adds out_parity (XOR of out_data, qualified by out_valid).
module nibble_pack16
  import alu_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  nibble_pack16_if.slave   bus
);

  localparam int                IDX_W  = idx_w(LANES);
  localparam int                WORD_W = LANES * LANE_W;
  localparam logic [IDX_W-1:0]  LAST   = IDX_W'(LANES - 1);

  pack_state_e        state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [LANES-1:0]   mask_q, mask_d;

  logic               in_fire;
  logic               out_fire;
  logic               flush_eff;
  logic [IDX_W-1:0]   base_cnt;

  assign bus.in_ready  = (state_q == ST_FILL) || bus.out_ready;
  assign bus.out_data  = word_q;
  assign bus.out_lanes = mask_q;
  assign bus.out_valid = (state_q == ST_FULL);

`ifdef NIBBLE_PACK_PARITY_EN
  assign bus.out_parity = (state_q == ST_FULL) && (^word_q);
`endif

  always_comb begin
    in_fire   = bus.in_valid && bus.in_ready;
    out_fire  = (state_q == ST_FULL) && bus.out_ready;
    flush_eff = bus.flush && (state_q == ST_FILL);

    // A draining word empties the register first, so a same-cycle lane lands in lane 0.
    word_d   = out_fire ? '0 : word_q;
    mask_d   = out_fire ? '0 : mask_q;
    base_cnt = out_fire ? '0 : cnt_q;
    cnt_d    = base_cnt;
    state_d  = out_fire ? ST_FILL : state_q;

    if (in_fire) begin
      word_d[base_cnt*LANE_W +: LANE_W] = bus.in_data;
      mask_d[base_cnt]                  = 1'b1;
      if ((base_cnt == LAST) || flush_eff) begin
        state_d = ST_FULL;
        cnt_d   = '0;
      end else begin
        cnt_d   = base_cnt + IDX_W'(1);
      end
    end else if (flush_eff && (base_cnt != '0)) begin
      state_d = ST_FULL;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      word_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_nibble_pack16.sv
// Self-checking bench for nibble_pack16: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_nibble_pack16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  nibble_pack16_if #(.LANES(4), .LANE_W(4)) bus ();

  nibble_pack16 #(.LANES(4), .LANE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, let the edge happen, then return just after it.
  task automatic put(input logic v, input logic [3:0] d, input logic f, input logic r);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.flush     = f;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 4'h0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
    n_checks++;
    if (bus.out_lanes !== 4'b0000) begin n_fail++; $display("FAIL reset_out_lanes: got %b want 0000", bus.out_lanes); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    put(1'b1, 4'h9, 1'b0, 1'b0);
    put(1'b1, 4'h8, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.out_lanes !== 4'b0000) begin n_fail++; $display("FAIL midrst_out_lanes: got %b want 0000", bus.out_lanes); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) put(1'b1, 4'(i), 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_word_valid: got %b want 1", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 16'h4321) begin n_fail++; $display("FAIL midrst_word_data: got %h want 4321", bus.out_data); end
    n_checks++;
    if (bus.out_lanes !== 4'b1111) begin n_fail++; $display("FAIL midrst_word_lanes: got %b want 1111", bus.out_lanes); end
  endtask

  // Entered with 16'h4321 held and out_ready low.
  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 4'hF, 1'b0, 1'b0);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4321 || bus.out_lanes !== 4'b1111) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b want v=1 d=4321 l=1111", i, bus.out_valid, bus.out_data, bus.out_lanes);
      end
    end
    put(1'b0, 4'h0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_lanes !== 4'b0000) begin
      n_fail++; $display("FAIL bp_drain: got v=%b l=%b want v=0 l=0000", bus.out_valid, bus.out_lanes);
    end
    put(1'b1, 4'h5, 1'b1, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0005 || bus.out_lanes !== 4'b0001) begin
      n_fail++; $display("FAIL bp_not_taken: got v=%b d=%h l=%b want v=1 d=0005 l=0001", bus.out_valid, bus.out_data, bus.out_lanes);
    end
    put(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_lane_order;
    logic [15:0] w;
    for (int i = 0; i < 4; i++) put(1'b1, 4'hA, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_data !== 16'hAAAA || bus.out_lanes !== 4'b1111) begin
      n_fail++; $display("FAIL order_aaaa: got d=%h l=%b want d=aaaa l=1111", bus.out_data, bus.out_lanes);
    end
    w = bus.out_data;
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (w[s*4 +: 4] !== 4'hA) begin n_fail++; $display("FAIL order_mux_a[%0d]: got %h want a", s, w[s*4 +: 4]); end
    end
    put(1'b1, 4'hC, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_lanes !== 4'b0001 || bus.out_data !== 16'h000C) begin
      n_fail++; $display("FAIL order_drain_fill: got v=%b d=%h l=%b want v=0 d=000c l=0001", bus.out_valid, bus.out_data, bus.out_lanes);
    end
    for (int i = 0; i < 3; i++) put(1'b1, 4'hC, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hCCCC) begin
      n_fail++; $display("FAIL order_cccc: got v=%b d=%h want v=1 d=cccc", bus.out_valid, bus.out_data);
    end
    w = bus.out_data;
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (w[s*4 +: 4] !== 4'hC) begin n_fail++; $display("FAIL order_mux_c[%0d]: got %h want c", s, w[s*4 +: 4]); end
    end
    put(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      put(1'b1, 4'(i), 1'b0, 1'b1);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      if (i == 3 || i == 7) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== ((i == 3) ? 16'h3210 : 16'h7654)) begin
          n_fail++; $display("FAIL b2b_word[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, (i == 3) ? 16'h3210 : 16'h7654);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_lanes !== 4'b0001) begin
          n_fail++; $display("FAIL b2b_restart: got v=%b l=%b want v=0 l=0001", bus.out_valid, bus.out_lanes);
        end
      end
    end
    put(1'b0, 4'h0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush;
    put(1'b1, 4'h5, 1'b0, 1'b0);
    put(1'b1, 4'h6, 1'b0, 1'b0);
    put(1'b0, 4'h0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0065 || bus.out_lanes !== 4'b0011) begin
      n_fail++; $display("FAIL flush_partial: got v=%b d=%h l=%b want v=1 d=0065 l=0011", bus.out_valid, bus.out_data, bus.out_lanes);
    end
    put(1'b0, 4'h0, 1'b0, 1'b1);
    put(1'b0, 4'h0, 1'b1, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", bus.out_valid); end
    put(1'b1, 4'h7, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0007 || bus.out_lanes !== 4'b0001) begin
      n_fail++; $display("FAIL flush_with_lane: got v=%b d=%h l=%b want v=1 d=0007 l=0001", bus.out_valid, bus.out_data, bus.out_lanes);
    end
    put(1'b1, 4'h9, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0007 || bus.out_lanes !== 4'b0001) begin
      n_fail++; $display("FAIL flush_in_full: got v=%b d=%h l=%b want v=1 d=0007 l=0001", bus.out_valid, bus.out_data, bus.out_lanes);
    end
    put(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

`ifdef NIBBLE_PACK_PARITY_EN
  task automatic test_parity;
    for (int i = 1; i <= 4; i++) put(1'b1, 4'(i), 1'b0, 1'b0);
    n_checks++;
    if (bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_4321: got %b want 1", bus.out_parity); end
    put(1'b0, 4'h0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_idle: got %b want 0", bus.out_parity); end
    for (int i = 0; i < 4; i++) put(1'b1, 4'hA, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_aaaa: got %b want 0", bus.out_parity); end
    put(1'b0, 4'h0, 1'b0, 1'b1);
  endtask
`endif

  // Reference: a queue of accepted lanes plus an optional completed word awaiting hand-off.
  task automatic test_random;
    int          q[$];
    logic        m_full;
    logic [15:0] m_word;
    logic [3:0]  m_mask;
    logic [15:0] part;
    logic        exp_rdy, in_fire, out_fire, was_full;
    m_full = 1'b0;
    m_word = '0;
    m_mask = '0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 4'($urandom);
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      part = '0;
      foreach (q[i]) part[i*4 +: 4] = 4'(q[i]);
      exp_rdy = !m_full || bus.out_ready;
      n_checks++;
      if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, bus.in_ready, exp_rdy); end
      n_checks++;
      if (bus.out_valid !== m_full) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b want %b", c, bus.out_valid, m_full); end
      n_checks++;
      if (m_full) begin
        if (bus.out_data !== m_word || bus.out_lanes !== m_mask) begin
          n_fail++; $display("FAIL rand_word[%0d]: got d=%h l=%b want d=%h l=%b", c, bus.out_data, bus.out_lanes, m_word, m_mask);
        end
      end else if (bus.out_data !== part || bus.out_lanes !== 4'((1 << q.size()) - 1)) begin
        n_fail++; $display("FAIL rand_partial[%0d]: got d=%h l=%b want d=%h l=%b", c, bus.out_data, bus.out_lanes, part, 4'((1 << q.size()) - 1));
      end
`ifdef NIBBLE_PACK_PARITY_EN
      n_checks++;
      if (bus.out_parity !== (m_full && (^m_word))) begin
        n_fail++; $display("FAIL rand_parity[%0d]: got %b want %b", c, bus.out_parity, m_full && (^m_word));
      end
`endif
      in_fire  = bus.in_valid && exp_rdy;
      out_fire = m_full && bus.out_ready;
      was_full = m_full;
      if (out_fire) m_full = 1'b0;
      if (!m_full) begin
        if (in_fire) q.push_back(int'(bus.in_data));
        if (q.size() == 4 || (bus.flush && !was_full && q.size() > 0)) begin
          m_word = '0;
          foreach (q[i]) m_word[i*4 +: 4] = 4'(q[i]);
          m_mask = 4'((1 << q.size()) - 1);
          m_full = 1'b1;
          q.delete();
        end
      end
      @(posedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reset_mid_fill();
    test_backpressure();
    test_lane_order();
    test_back_to_back();
    test_flush();
`ifdef NIBBLE_PACK_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
